csr_file_tmr: RTL and testbench
===============================

// Module: csr_file_tmr
// PURPOSE
// - LA32R CSR file, successor of the basic exception CSR block: adds ECFG/BADV/TID/TCFG/TVAL/TICLR.
// - Adds a configurable count-down timer, hardware/IPI interrupt sampling and a has_int request.
// - Makes the SAVE count and timer width parametrisable.
// - Sits beside the WB stage: read/write port for csrrd/csrwr/csrxchg, exception/ertn update port.
// PARAMETERS
// - SAVE_NUM   4   implemented SAVEn registers, 1..16, at 0x30+n
// - TIMER_W    32  timer counter width, 8..32
// - HWI_NUM    8   hardware interrupt lines, 1..8, mapped to ESTAT.IS[2+:HWI_NUM]
// - TID_RESET  0   reset value of TID (32b)
// PORTS
// - clk          in   1        clock
// - reset        in   1        synchronous, active-high
// - csr_re       in   1        read enable
// - csr_num      in   14       CSR number
// - csr_rvalue   out  32       read data; 0 when csr_re=0 or number unimplemented
// - csr_we       in   1        write enable
// - csr_wmask    in   32       per-bit write mask
// - csr_wvalue   in   32       write data
// - wb_ex        in   1        exception commit
// - wb_ecode     in   6        exception code
// - wb_esubcode  in   9        exception sub-code
// - wb_pc        in   32       faulting PC
// - wb_vaddr     in   32       faulting address
// - ertn_flush   in   1        ertn commit
// - hw_int_in    in   HWI_NUM  level hardware interrupts
// - ipi_int_in   in   1        inter-processor interrupt, level
// - ex_entry     out  32       EENTRY value
// - era_out      out  32       ERA value, ertn target
// - has_int      out  1        interrupt request to the pipeline
// BEHAVIOUR
// - Map: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVEn 0x30+n, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
// - Read path is combinational. A write is visible on the next cycle: new = wmask&wvalue | ~wmask&old, writable bits only.
// - Update priority: reset > wb_ex > ertn_flush > csr_we.
//   - Cycle with wb_ex=1 or ertn_flush=1: csr_we is ignored entirely.
// - Reset values: CRMD = 0x8 (PLV=0, IE=0, DA=1, PG=0).
//   - PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVEn, TCFG = 0.
//   - TID = TID_RESET; timer counter = all-ones.
//   - Outputs after reset: ex_entry=0, era_out=0, has_int=0.
// - Fields:
//   - CRMD {DA,IE,PLV[1:0]}; DA reads 1, PG/DATF/DATM read 0.
//   - PRMD {PIE,PPLV}.
//   - ECFG.LIE [12:0], bit 10 reads 0.
//   - ESTAT {ESUBCODE[30:22],ECODE[21:16],IS[12:0]}; only IS[1:0] software-writable.
//   - EENTRY VA[31:6].
//   - TCFG {INITVAL[TIMER_W-1:2],PERIODIC,EN}, upper bits read 0.
//   - TVAL read-only, counter zero-extended.
//   - TICLR reads 0.
// - On wb_ex:
//   - PRMD <= {CRMD.IE, CRMD.PLV}; CRMD.PLV <= 0, IE <= 0.
//   - ERA <= wb_pc; ESTAT.ECODE/ESUBCODE <= wb_ecode/wb_esubcode.
//   - BADV <= wb_vaddr only when wb_ecode is 0x08 (ADE) or 0x09 (ALE).
// - On ertn_flush: CRMD.PLV <= PRMD.PPLV, CRMD.IE <= PRMD.PIE.
// - IS sampling:
//   - IS[2+:HWI_NUM] <= hw_int_in every cycle (1-cycle latency); unused IS[9:2] bits = 0.
//   - IS[12] <= ipi_int_in every cycle; IS[10] = 0.
// - Timer:
//   - Write to TCFG loads counter <= {wvalue[TIMER_W-1:2],2'b00} in the same clock as the TCFG update.
//   - Otherwise, while EN=1 and counter != all-ones: counter decrements by 1.
//   - EN=1 and counter==0 sets IS[11].
//     - PERIODIC=1: counter reloads {INITVAL,2'b00} instead of wrapping.
//     - PERIODIC=0: counter wraps to all-ones and stops, giving exactly one interrupt.
//   - EN=0 freezes the counter.
//   - INITVAL=0 with PERIODIC=1 raises IS[11] every cycle.
// - TICLR: write with wmask[0]&wvalue[0]=1 clears IS[11] next cycle.
//   - Same cycle as a timer hit: set wins, IS[11] stays 1.
// - has_int = CRMD.IE & |(ESTAT.IS & ECFG.LIE), combinational from registered state.
// - Unimplemented numbers, and SAVEn with n >= SAVE_NUM: writes dropped, reads return 0.
// - Reset mid-count: counter forced to all-ones, TCFG.EN=0, IS cleared.
// TESTING
// - Write EENTRY=0x1C008000, then wb_ex(ecode 0x0B, pc 0x1C000100) with CRMD.IE=1, PLV=3:
//   - ex_entry=0x1C008000, ERA=0x1C000100, PRMD=0x7, CRMD=0x8, ESTAT[21:16]=0x0B, BADV unchanged.
//   - Then ertn_flush -> CRMD=0xF.
// - wb_ex ecode 0x09, vaddr 0x00000003 -> BADV=0x3.
//   - Same cycle csr_we to SAVE0=0x55 -> SAVE0 unchanged.
// - TCFG=0x0000000B (INITVAL=2, PERIODIC, EN): TVAL reads 8,7,...,0.
//   - Then IS[11]=1 and TVAL=8 again.
//   - With ECFG.LIE[11]=1 and CRMD.IE=1: has_int=1.
//   - TICLR write 1 while TVAL>0 -> IS[11]=0, has_int=0.
// - TCFG=0x00000009 (one-shot, INITVAL=2): single IS[11] set.
//   - TVAL then holds 0xFFFFFFFF and no re-assertion within 100 cycles.
// - hw_int_in[3]=1 with LIE[5]=1, IE=1:
//   - has_int rises exactly 1 cycle later.
//   - Drop hw_int_in -> IS[5] and has_int fall 1 cycle later.
// - SAVE_NUM=2: write 0x32 -> read 0.
//   - Masked write to SAVE1: mask 0x0000FFFF, value 0x12345678 over 0xAAAAAAAA -> 0xAAAA5678.
//   - Read of TICLR -> 0.

Source files
------------

// File: rtl/csr_file_tmr_if.sv
// Port bundle between the WB stage and the CSR file: csr read/write port,
// exception/ertn commit, interrupt inputs and the entry/return/interrupt outputs.
interface csr_file_tmr_if #(
    parameter int HWI_NUM = 8
);
    logic               csr_re;
    logic [13:0]        csr_num;
    logic [31:0]        csr_rvalue;
    logic               csr_we;
    logic [31:0]        csr_wmask;
    logic [31:0]        csr_wvalue;
    logic               wb_ex;
    logic [5:0]         wb_ecode;
    logic [8:0]         wb_esubcode;
    logic [31:0]        wb_pc;
    logic [31:0]        wb_vaddr;
    logic               ertn_flush;
    logic [HWI_NUM-1:0] hw_int_in;
    logic               ipi_int_in;
    logic [31:0]        ex_entry;
    logic [31:0]        era_out;
    logic               has_int;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               hw_int_in, ipi_int_in,
        input  csr_rvalue, ex_entry, era_out, has_int
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               hw_int_in, ipi_int_in,
        output csr_rvalue, ex_entry, era_out, has_int
    );
endinterface

// File: rtl/csr_file_tmr.sv
// LA32R CSR file with exception/ertn update, SAVEn scratch registers,
// a count-down timer and interrupt sampling feeding the has_int request.
module csr_file_tmr #(
    parameter int          SAVE_NUM  = 4,
    parameter int          TIMER_W   = 32,
    parameter int          HWI_NUM   = 8,
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    csr_file_tmr_if.slave bus
);
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;
    localparam logic [5:0]  ECODE_ADE  = 6'h08;
    localparam logic [5:0]  ECODE_ALE  = 6'h09;

    logic [1:0]         crmd_plv_q,  crmd_plv_d;
    logic               crmd_ie_q,   crmd_ie_d;
    logic [1:0]         prmd_pplv_q, prmd_pplv_d;
    logic               prmd_pie_q,  prmd_pie_d;
    logic [12:0]        ecfg_lie_q,  ecfg_lie_d;
    logic [1:0]         is_sw_q,     is_sw_d;
    logic [HWI_NUM-1:0] is_hw_q,     is_hw_d;
    logic               is_timer_q,  is_timer_d;
    logic               is_ipi_q,    is_ipi_d;
    logic [5:0]         ecode_q,     ecode_d;
    logic [8:0]         esub_q,      esub_d;
    logic [31:0]        era_q,       era_d;
    logic [31:0]        badv_q,      badv_d;
    logic [25:0]        eentry_va_q, eentry_va_d;
    logic [31:0]        tid_q,       tid_d;
    logic [TIMER_W-1:0] tcfg_q,      tcfg_d;
    logic [TIMER_W-1:0] timer_cnt_q, timer_cnt_d;

    logic [12:0] is_vec;
    logic [31:0] crmd_rd, prmd_rd, ecfg_rd, estat_rd, eentry_rd, tcfg_rd, tval_rd;
    logic [31:0] csr_raw;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        save_hit;
    logic        timer_hit;
    logic        ticlr_clr;
    logic [31:0] save_rd [16];

    assign is_vec    = {is_ipi_q, is_timer_q, 1'b0, 8'(is_hw_q), is_sw_q};
    assign crmd_rd   = {28'd0, 1'b1, crmd_ie_q, crmd_plv_q};
    assign prmd_rd   = {29'd0, prmd_pie_q, prmd_pplv_q};
    assign ecfg_rd   = {19'd0, ecfg_lie_q};
    assign estat_rd  = {1'b0, esub_q, ecode_q, 3'd0, is_vec};
    assign eentry_rd = {eentry_va_q, 6'd0};
    assign tcfg_rd   = 32'(tcfg_q);
    assign tval_rd   = 32'(timer_cnt_q);

    // Software writes lose to any exception or ertn commit in the same cycle.
    assign wr_en     = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
    assign save_hit  = (bus.csr_num[13:4] == 10'h003) &&
                       ({1'b0, bus.csr_num[3:0]} < 5'(SAVE_NUM));
    assign wr_data   = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & csr_raw);
    assign timer_hit = tcfg_q[0] && (timer_cnt_q == '0);
    assign ticlr_clr = wr_en && (bus.csr_num == CSR_TICLR) &&
                       bus.csr_wmask[0] && bus.csr_wvalue[0];

    for (genvar gi = 0; gi < 16; gi++) begin : g_save
        if (gi < SAVE_NUM) begin : g_impl
            logic [31:0] save_q, save_d;
            assign save_d = (wr_en && save_hit && bus.csr_num[3:0] == 4'(gi)) ? wr_data : save_q;
            always_ff @(posedge clk) begin
                if (reset) save_q <= '0;
                else       save_q <= save_d;
            end
            assign save_rd[gi] = save_q;
        end else begin : g_none
            assign save_rd[gi] = '0;
        end
    end

    always_comb begin
        csr_raw = '0;
        case (bus.csr_num)
            CSR_CRMD:   csr_raw = crmd_rd;
            CSR_PRMD:   csr_raw = prmd_rd;
            CSR_ECFG:   csr_raw = ecfg_rd;
            CSR_ESTAT:  csr_raw = estat_rd;
            CSR_ERA:    csr_raw = era_q;
            CSR_BADV:   csr_raw = badv_q;
            CSR_EENTRY: csr_raw = eentry_rd;
            CSR_TID:    csr_raw = tid_q;
            CSR_TCFG:   csr_raw = tcfg_rd;
            CSR_TVAL:   csr_raw = tval_rd;
            CSR_TICLR:  csr_raw = '0;
            default:    if (save_hit) csr_raw = save_rd[bus.csr_num[3:0]];
        endcase
    end

    always_comb begin
        crmd_plv_d  = crmd_plv_q;
        crmd_ie_d   = crmd_ie_q;
        prmd_pplv_d = prmd_pplv_q;
        prmd_pie_d  = prmd_pie_q;
        ecfg_lie_d  = ecfg_lie_q;
        is_sw_d     = is_sw_q;
        ecode_d     = ecode_q;
        esub_d      = esub_q;
        era_d       = era_q;
        badv_d      = badv_q;
        eentry_va_d = eentry_va_q;
        tid_d       = tid_q;
        tcfg_d      = tcfg_q;
        timer_cnt_d = timer_cnt_q;
        is_timer_d  = is_timer_q;
        is_hw_d     = bus.hw_int_in;
        is_ipi_d    = bus.ipi_int_in;

        if (bus.wb_ex) begin
            prmd_pplv_d = crmd_plv_q;
            prmd_pie_d  = crmd_ie_q;
            crmd_plv_d  = 2'd0;
            crmd_ie_d   = 1'b0;
            era_d       = bus.wb_pc;
            ecode_d     = bus.wb_ecode;
            esub_d      = bus.wb_esubcode;
            if (bus.wb_ecode == ECODE_ADE || bus.wb_ecode == ECODE_ALE) badv_d = bus.wb_vaddr;
        end else if (bus.ertn_flush) begin
            crmd_plv_d = prmd_pplv_q;
            crmd_ie_d  = prmd_pie_q;
        end else if (bus.csr_we) begin
            case (bus.csr_num)
                CSR_CRMD:   begin crmd_plv_d = wr_data[1:0]; crmd_ie_d = wr_data[2]; end
                CSR_PRMD:   begin prmd_pplv_d = wr_data[1:0]; prmd_pie_d = wr_data[2]; end
                CSR_ECFG:   ecfg_lie_d  = wr_data[12:0] & 13'h1BFF;
                CSR_ESTAT:  is_sw_d     = wr_data[1:0];
                CSR_ERA:    era_d       = wr_data;
                CSR_BADV:   badv_d      = wr_data;
                CSR_EENTRY: eentry_va_d = wr_data[31:6];
                CSR_TID:    tid_d       = wr_data;
                CSR_TCFG:   tcfg_d      = wr_data[TIMER_W-1:0];
                default: ;
            endcase
        end

        // All-ones is the idle state: a one-shot timer parks there after firing.
        if (wr_en && bus.csr_num == CSR_TCFG) begin
            timer_cnt_d = {bus.csr_wvalue[TIMER_W-1:2], 2'b00};
        end else if (tcfg_q[0] && timer_cnt_q != '1) begin
            if (timer_cnt_q == '0) timer_cnt_d = tcfg_q[1] ? {tcfg_q[TIMER_W-1:2], 2'b00} : '1;
            else                   timer_cnt_d = timer_cnt_q - TIMER_W'(1);
        end

        if (timer_hit)      is_timer_d = 1'b1;
        else if (ticlr_clr) is_timer_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_plv_q  <= '0;
            crmd_ie_q   <= 1'b0;
            prmd_pplv_q <= '0;
            prmd_pie_q  <= 1'b0;
            ecfg_lie_q  <= '0;
            is_sw_q     <= '0;
            is_hw_q     <= '0;
            is_timer_q  <= 1'b0;
            is_ipi_q    <= 1'b0;
            ecode_q     <= '0;
            esub_q      <= '0;
            era_q       <= '0;
            badv_q      <= '0;
            eentry_va_q <= '0;
            tid_q       <= TID_RESET;
            tcfg_q      <= '0;
            timer_cnt_q <= '1;
        end else begin
            crmd_plv_q  <= crmd_plv_d;
            crmd_ie_q   <= crmd_ie_d;
            prmd_pplv_q <= prmd_pplv_d;
            prmd_pie_q  <= prmd_pie_d;
            ecfg_lie_q  <= ecfg_lie_d;
            is_sw_q     <= is_sw_d;
            is_hw_q     <= is_hw_d;
            is_timer_q  <= is_timer_d;
            is_ipi_q    <= is_ipi_d;
            ecode_q     <= ecode_d;
            esub_q      <= esub_d;
            era_q       <= era_d;
            badv_q      <= badv_d;
            eentry_va_q <= eentry_va_d;
            tid_q       <= tid_d;
            tcfg_q      <= tcfg_d;
            timer_cnt_q <= timer_cnt_d;
        end
    end

    assign bus.csr_rvalue = bus.csr_re ? csr_raw : 32'd0;
    assign bus.ex_entry   = eentry_rd;
    assign bus.era_out    = era_q;
    assign bus.has_int    = crmd_ie_q & |(is_vec & ecfg_lie_q);
endmodule

// File: tb/tb_csr_file_tmr.sv
// Bench for csr_file_tmr: directed scenarios plus random traffic, all checked
// against an architectural-image model of the CSR file.
module tb_csr_file_tmr;
    localparam int          SAVE_NUM  = 2;
    localparam int          TIMER_W   = 32;
    localparam int          HWI_NUM   = 8;
    localparam logic [31:0] TID_RESET = 32'h0000_0A5A;

    logic clk = 1'b0;
    logic reset;
    always #50 clk = ~clk;

    csr_file_tmr_if #(.HWI_NUM(HWI_NUM)) bus ();

    csr_file_tmr #(
        .SAVE_NUM(SAVE_NUM), .TIMER_W(TIMER_W), .HWI_NUM(HWI_NUM), .TID_RESET(TID_RESET)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Model: one 32-bit architectural image per CSR number plus the timer count.
    logic [31:0] arch    [128];
    logic [31:0] nx_arch [128];
    logic [31:0] cnt, nx_cnt;

    logic [13:0] sweep_list [16] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                                     14'h00C, 14'h030, 14'h031, 14'h032, 14'h040, 14'h041,
                                     14'h042, 14'h044, 14'h002, 14'h3FFF};
    logic [13:0] rand_list [16]  = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                                     14'h00C, 14'h030, 14'h031, 14'h032, 14'h040, 14'h041,
                                     14'h042, 14'h044, 14'h041, 14'h2044};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic is_save(input logic [13:0] n);
        return (n >= 14'h030) && (n < 14'(32'h30 + SAVE_NUM));
    endfunction

    function automatic logic [31:0] wmask_of(input logic [13:0] n);
        case (n)
            14'h000, 14'h001:           return 32'h0000_0007;
            14'h004:                    return 32'h0000_1BFF;
            14'h005:                    return 32'h0000_0003;
            14'h006, 14'h007, 14'h040:  return 32'hFFFF_FFFF;
            14'h00C:                    return 32'hFFFF_FFC0;
            14'h041:                    return 32'hFFFF_FFFF;
            default:                    return is_save(n) ? 32'hFFFF_FFFF : 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] n);
        if (n == 14'h042) return cnt;
        if (n == 14'h044) return 32'h0;
        if (wmask_of(n) == 32'h0 && n != 14'h005) return 32'h0;
        return arch[n[6:0]];
    endfunction

    function automatic logic model_has_int();
        return arch[0][2] && (|(arch[5][12:0] & arch[4][12:0]));
    endfunction

    task automatic model_step();
        logic [31:0] wm, merged, tcfg_now;
        logic        hit, clr, wr;
        logic [6:0]  a;
        nx_arch = arch;
        nx_cnt  = cnt;
        if (reset) begin
            for (int i = 0; i < 128; i++) nx_arch[i] = 32'h0;
            nx_arch[0]     = 32'h8;
            nx_arch[7'h40] = TID_RESET;
            nx_cnt         = 32'hFFFF_FFFF;
            return;
        end
        wr       = bus.csr_we && !bus.wb_ex && !bus.ertn_flush;
        a        = bus.csr_num[6:0];
        tcfg_now = arch[7'h41];
        if (bus.wb_ex) begin
            nx_arch[1]         = {29'd0, arch[0][2:0]};
            nx_arch[0]         = 32'h8;
            nx_arch[6]         = bus.wb_pc;
            nx_arch[5][30:16]  = {bus.wb_esubcode, bus.wb_ecode};
            if (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09) nx_arch[7] = bus.wb_vaddr;
        end else if (bus.ertn_flush) begin
            nx_arch[0] = 32'h8 | {29'd0, arch[1][2:0]};
        end else if (wr) begin
            wm     = wmask_of(bus.csr_num);
            merged = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & arch[a]);
            if (wm != 32'h0) nx_arch[a] = (arch[a] & ~wm) | (merged & wm);
        end
        hit = tcfg_now[0] && (cnt == 32'h0);
        clr = wr && bus.csr_num == 14'h044 && bus.csr_wmask[0] && bus.csr_wvalue[0];
        if (wr && bus.csr_num == 14'h041)
            nx_cnt = bus.csr_wvalue & 32'hFFFF_FFFC;
        else if (tcfg_now[0] && cnt != 32'hFFFF_FFFF)
            nx_cnt = (cnt == 32'h0) ? (tcfg_now[1] ? (tcfg_now & 32'hFFFF_FFFC) : 32'hFFFF_FFFF)
                                    : cnt - 32'd1;
        nx_arch[5][12]  = bus.ipi_int_in;
        nx_arch[5][11]  = hit ? 1'b1 : (clr ? 1'b0 : arch[5][11]);
        nx_arch[5][10]  = 1'b0;
        nx_arch[5][9:2] = 8'(bus.hw_int_in);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        arch = nx_arch;
        cnt  = nx_cnt;
        cyc++;
        #1;
    endtask

    task automatic idle();
        bus.csr_we     = 1'b0;
        bus.csr_wmask  = 32'h0;
        bus.csr_wvalue = 32'h0;
        bus.wb_ex      = 1'b0;
        bus.ertn_flush = 1'b0;
    endtask

    task automatic rd(input logic [13:0] n, output logic [31:0] v);
        bus.csr_re  = 1'b1;
        bus.csr_num = n;
        #1;
        v = bus.csr_rvalue;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] n);
        logic [31:0] v;
        rd(n, v);
        check(tag, v, model_read(n));
    endtask

    task automatic out_chk();
        check("ex_entry", bus.ex_entry, arch[12]);
        check("era_out", bus.era_out, arch[6]);
        check("has_int", {31'd0, bus.has_int}, {31'd0, model_has_int()});
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("%s_csr%03h", tag, sweep_list[i]), sweep_list[i]);
        out_chk();
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        idle();
        bus.csr_we = 1'b1; bus.csr_num = n; bus.csr_wmask = m; bus.csr_wvalue = v;
        tick();
        idle();
        $display("cyc %0d write csr=%03h mask=%08h val=%08h", cyc, n, m, v);
    endtask

    task automatic exc(input logic [5:0] ec, input logic [31:0] pc, input logic [31:0] va);
        bus.wb_ex = 1'b1; bus.wb_ecode = ec; bus.wb_esubcode = 9'h0; bus.wb_pc = pc; bus.wb_vaddr = va;
        tick();
        idle();
        $display("cyc %0d exception ecode=%02h pc=%08h vaddr=%08h", cyc, ec, pc, va);
    endtask

    initial begin
        logic [31:0] v;
        int          rises;
        reset = 1'b1;
        bus.csr_re = 1'b0; bus.csr_num = '0; bus.wb_ecode = '0; bus.wb_esubcode = '0;
        bus.wb_pc = '0; bus.wb_vaddr = '0; bus.hw_int_in = '0; bus.ipi_int_in = 1'b0;
        idle();
        for (int i = 0; i < 128; i++) arch[i] = 32'hDEAD_0000;
        cnt = 32'h0;
        tick(); tick();
        reset = 1'b0;
        $display("cyc %0d reset released", cyc);
        sweep("reset");
        rd(14'h000, v);  check("reset_crmd", v, 32'h8);
        rd(14'h040, v);  check("reset_tid", v, TID_RESET);
        rd(14'h042, v);  check("reset_tval", v, 32'hFFFF_FFFF);
        check("reset_has_int", {31'd0, bus.has_int}, 32'h0);

        // Exception entry and ertn return
        wr(14'h00C, 32'hFFFF_FFFF, 32'h1C00_8000);
        wr(14'h000, 32'hFFFF_FFFF, 32'h0000_0007);
        exc(6'h0B, 32'h1C00_0100, 32'h1234_5678);
        check("ex_entry_val", bus.ex_entry, 32'h1C00_8000);
        check("era_val", bus.era_out, 32'h1C00_0100);
        rd(14'h001, v); check("prmd_after_ex", v, 32'h7);
        rd(14'h000, v); check("crmd_after_ex", v, 32'h8);
        rd(14'h005, v); check("estat_ecode", {26'd0, v[21:16]}, 32'h0B);
        rd(14'h007, v); check("badv_unchanged", v, 32'h0);
        bus.ertn_flush = 1'b1; tick(); idle();
        $display("cyc %0d ertn", cyc);
        rd(14'h000, v); check("crmd_after_ertn", v, 32'hF);
        sweep("exc");

        // ALE records BADV; a simultaneous csr write is dropped
        wr(14'h030, 32'hFFFF_FFFF, 32'h0000_0011);
        bus.csr_we = 1'b1; bus.csr_num = 14'h030; bus.csr_wmask = 32'hFFFF_FFFF; bus.csr_wvalue = 32'h55;
        exc(6'h09, 32'h1C00_0200, 32'h0000_0003);
        rd(14'h007, v); check("badv_ale", v, 32'h3);
        rd(14'h030, v); check("save0_kept", v, 32'h11);

        // SAVE range, masked write, TICLR read
        wr(14'h032, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        rd(14'h032, v); check("save2_unimpl", v, 32'h0);
        wr(14'h031, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
        wr(14'h031, 32'h0000_FFFF, 32'h1234_5678);
        rd(14'h031, v); check("save1_masked", v, 32'hAAAA_5678);
        rd(14'h044, v); check("ticlr_read", v, 32'h0);
        sweep("save");

        // Periodic timer, INITVAL=2
        wr(14'h000, 32'hFFFF_FFFF, 32'h4);
        wr(14'h004, 32'hFFFF_FFFF, 32'h800);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
        for (int k = 0; k < 9; k++) begin
            rd(14'h042, v); check("tval_seq", v, 32'(8 - k));
            rd(14'h005, v); check("is11_quiet", {31'd0, v[11]}, 32'h0);
            tick();
        end
        rd(14'h042, v); check("tval_reload", v, 32'h8);
        rd(14'h005, v); check("is11_set", {31'd0, v[11]}, 32'h1);
        check("has_int_timer", {31'd0, bus.has_int}, 32'h1);
        wr(14'h044, 32'h1, 32'h1);
        rd(14'h005, v); check("is11_cleared", {31'd0, v[11]}, 32'h0);
        check("has_int_cleared", {31'd0, bus.has_int}, 32'h0);
        sweep("periodic");

        // One-shot timer fires once then parks at all-ones
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0009);
        for (int k = 0; k < 8; k++) tick();
        rd(14'h005, v); check("oneshot_pre", {31'd0, v[11]}, 32'h0);
        tick();
        rd(14'h005, v); check("oneshot_fire", {31'd0, v[11]}, 32'h1);
        rd(14'h042, v); check("oneshot_park", v, 32'hFFFF_FFFF);
        wr(14'h044, 32'h1, 32'h1);
        rises = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            rd(14'h005, v);
            if (v[11]) rises++;
        end
        check("oneshot_no_refire", 32'(rises), 32'h0);
        rd(14'h042, v); check("oneshot_still_park", v, 32'hFFFF_FFFF);

        // Hardware interrupt line 3 -> IS[5], one-cycle sampling latency
        wr(14'h041, 32'hFFFF_FFFF, 32'h0);
        wr(14'h004, 32'hFFFF_FFFF, 32'h20);
        bus.hw_int_in = 8'h08; #1;
        check("hwi_before_edge", {31'd0, bus.has_int}, 32'h0);
        tick();
        check("hwi_rise", {31'd0, bus.has_int}, 32'h1);
        rd(14'h005, v); check("is5_set", {31'd0, v[5]}, 32'h1);
        bus.hw_int_in = 8'h00; #1;
        check("hwi_hold", {31'd0, bus.has_int}, 32'h1);
        tick();
        check("hwi_fall", {31'd0, bus.has_int}, 32'h0);
        rd(14'h005, v); check("is5_clear", {31'd0, v[5]}, 32'h0);
        sweep("hwi");

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            logic [13:0] n;
            idle();
            n = rand_list[$urandom_range(0, 15)];
            bus.csr_num    = n;
            bus.csr_re     = ($urandom_range(0, 7) != 0);
            bus.csr_we     = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 2))
                0:       bus.csr_wmask = 32'hFFFF_FFFF;
                1:       bus.csr_wmask = 32'h1;
                default: bus.csr_wmask = $urandom;
            endcase
            bus.csr_wvalue = (n == 14'h041) ? (($urandom_range(0, 4) << 2) | $urandom_range(0, 3))
                                            : $urandom;
            bus.wb_ex      = ($urandom_range(0, 15) == 0);
            bus.ertn_flush = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       bus.wb_ecode = 6'h08;
                1:       bus.wb_ecode = 6'h09;
                default: bus.wb_ecode = 6'($urandom);
            endcase
            bus.wb_esubcode = 9'($urandom);
            bus.wb_pc       = $urandom;
            bus.wb_vaddr    = $urandom;
            bus.hw_int_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            bus.ipi_int_in  = ($urandom_range(0, 7) == 0);
            #1;
            check("rand_rvalue", bus.csr_rvalue, bus.csr_re ? model_read(n) : 32'h0);
            out_chk();
            $display("cyc %0d rand re=%0b we=%0b csr=%03h ex=%0b ertn=%0b rvalue=%08h has_int=%0b",
                     cyc, bus.csr_re, bus.csr_we, n, bus.wb_ex, bus.ertn_flush, bus.csr_rvalue, bus.has_int);
            tick();
        end
        idle();
        bus.hw_int_in = 8'h0; bus.ipi_int_in = 1'b0;
        tick();
        sweep("rand_end");

        // Reset in the middle of a count
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_1003);
        wr(14'h005, 32'hFFFF_FFFF, 32'h3);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        $display("cyc %0d mid-count reset", cyc);
        rd(14'h042, v); check("rst_tval", v, 32'hFFFF_FFFF);
        rd(14'h041, v); check("rst_tcfg", v, 32'h0);
        rd(14'h005, v); check("rst_estat", v, 32'h0);
        sweep("midreset");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
